// File: rtl/nios2_debug_cmd_sync_if.sv
// Command handshake between the debug command receiver (master) and its OCI consumer (slave).
// A command is offered while cmd_valid=1 and is taken in any cycle where cmd_valid && cmd_ready;
// jdo/cmd_ir hold steady while cmd_valid=1, and take_* pulse for exactly that accept cycle.
interface nios2_debug_cmd_sync_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                       cmd_ready;
  logic                       cmd_valid;
  logic [SR_WIDTH-1:0]        jdo;
  logic [IR_WIDTH-1:0]        cmd_ir;
  logic [(1<<IR_WIDTH)-1:0]   take_action;
  logic [(1<<IR_WIDTH)-1:0]   take_no_action;

  modport master (
    input  cmd_ready,
    output cmd_valid, jdo, cmd_ir, take_action, take_no_action
  );

  modport slave (
    output cmd_ready,
    input  cmd_valid, jdo, cmd_ir, take_action, take_no_action
  );
endinterface

// File: rtl/nios2_debug_cmd_sync.sv
// clk-side receiver for the Nios II JTAG debug slave: syncs update-IR/DR, latches jdo, decodes strobes.
// Optional pending-command timeout is enabled with `define DEBUG_CMD_TIMEOUT_EN.
module nios2_debug_cmd_sync #(
  parameter int SR_WIDTH       = 38,
  parameter int IR_WIDTH       = 2,
  parameter int ACTION_BIT     = 37,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vs_uir,
  input  logic                vs_udr,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                overrun_clr,
  nios2_debug_cmd_sync_if.master cmd,
  output logic                overrun,
  output logic                timeout,
  output logic [0:0]          dbg_state
);
  localparam int NCMD = 1 << IR_WIDTH;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync;
  logic                   r_udr_hist, r_uir_hist;
  logic [IR_WIDTH-1:0]    r_ir_q, r_cmd_ir;
  logic [SR_WIDTH-1:0]    r_jdo;
  logic [0:0]             r_state;
  logic                   r_overrun;

  logic                   w_udr_edge, w_uir_edge, w_hs, w_pend, w_overrun_set, w_to_fire;
  logic [IR_WIDTH-1:0]    w_ir_eff;
  logic [NCMD-1:0]        w_onehot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_hist <= 1'b0;
      r_uir_hist <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
      r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
    end
  end

  assign w_udr_edge    = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
  assign w_uir_edge    = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
  // A same-cycle update-IR must bind its new instruction to the command captured alongside it.
  assign w_ir_eff      = w_uir_edge ? ir_in : r_ir_q;
  assign w_pend        = (r_state == ST_PEND);
  assign w_hs          = w_pend & cmd.cmd_ready;
  assign w_overrun_set = w_pend & ~cmd.cmd_ready & w_udr_edge;

  always_comb begin
    w_onehot           = '0;
    w_onehot[r_cmd_ir] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_q    <= '0;
      r_cmd_ir  <= '0;
      r_jdo     <= '0;
      r_state   <= ST_IDLE;
      r_overrun <= 1'b0;
    end else begin
      if (w_uir_edge) r_ir_q <= ir_in;
      case (r_state)
        ST_IDLE: begin
          if (w_udr_edge) begin
            r_jdo    <= sr;
            r_cmd_ir <= w_ir_eff;
            r_state  <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (cmd.cmd_ready) begin
            if (w_udr_edge) begin
              r_jdo    <= sr;
              r_cmd_ir <= w_ir_eff;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_to_fire) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_overrun_set)    r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

`ifdef DEBUG_CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;

  // The counter only advances while a command waits unaccepted; any other cycle restarts it.
  assign w_to_fire = w_pend & ~cmd.cmd_ready & (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_pend && !cmd.cmd_ready && !w_to_fire) r_to_cnt <= r_to_cnt + 1'b1;
      else                                        r_to_cnt <= '0;
      if (w_to_fire)        r_timeout <= 1'b1;
      else if (overrun_clr) r_timeout <= 1'b0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign cmd.cmd_valid      = w_pend;
  assign cmd.jdo            = r_jdo;
  assign cmd.cmd_ir         = r_cmd_ir;
  assign cmd.take_action    = (w_hs &  r_jdo[ACTION_BIT]) ? w_onehot : '0;
  assign cmd.take_no_action = (w_hs & ~r_jdo[ACTION_BIT]) ? w_onehot : '0;
  assign overrun            = r_overrun;
  assign dbg_state          = r_state;
endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Directed bench for nios2_debug_cmd_sync: latency, strobes, backpressure, overrun, timeout, reset.
// Inputs change 1ns after posedge; outputs are sampled 1ns after posedge.
module tb_nios2_debug_cmd_sync;
  localparam int SR_W = 38;
  localparam int IR_W = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_uir = 1'b0, vs_udr = 1'b0, overrun_clr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            overrun, timeout;
  logic [0:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int pend_cnt, take_cnt;

  nios2_debug_cmd_sync_if #(.SR_WIDTH(SR_W), .IR_WIDTH(IR_W)) cmd_if ();

  nios2_debug_cmd_sync #(
    .SR_WIDTH(SR_W), .IR_WIDTH(IR_W), .ACTION_BIT(37), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .overrun_clr(overrun_clr), .cmd(cmd_if.master), .overrun(overrun), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  // Raise vs_udr with data and step three edges so the command is captured.
  task automatic udr_capture(input logic [SR_W-1:0] v);
    sr     = v;
    vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    #12;
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_jdo", cmd_if.jdo, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    tick();

    // Basic action with ready already high: valid on the third edge after vs_udr rises.
    load_ir(2'b01);
    cmd_if.cmd_ready = 1'b1;
    sr = 38'h20_0000_1234;
    vs_udr = 1'b1;
    tick(); check("lat_e1", cmd_if.cmd_valid, 0);
    tick(); check("lat_e2", cmd_if.cmd_valid, 0);
    tick();
    check("lat_e3", cmd_if.cmd_valid, 1);
    check("act_jdo", cmd_if.jdo, 38'h20_0000_1234);
    check("act_strobe", cmd_if.take_action, 4'b0010);
    check("act_noact", cmd_if.take_no_action, 0);
    vs_udr = 1'b0;
    tick();
    check("act_done", cmd_if.cmd_valid, 0);
    check("act_pulse1", cmd_if.take_action, 0);
    cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();

    // No-action with five cycles of backpressure.
    load_ir(2'b10);
    udr_capture(38'h00_0000_0055);
    check("bp_valid0", cmd_if.cmd_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", cmd_if.cmd_valid, 1);
      check("bp_jdo", cmd_if.jdo, 38'h00_0000_0055);
      check("bp_nostrobe", cmd_if.take_no_action, 0);
    end
    cmd_if.cmd_ready = 1'b1;
    #1;
    check("bp_noact", cmd_if.take_no_action, 4'b0100);
    check("bp_act", cmd_if.take_action, 0);
    tick();
    check("bp_done", cmd_if.cmd_valid, 0);
    check("bp_pulse1", cmd_if.take_no_action, 0);
    cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();

    // Overrun: second update while pending and not ready.
    udr_capture(38'h20_0000_00AA);
    repeat (3) tick();
    udr_capture(38'h1);
    check("ovr_set", overrun, 1);
    check("ovr_jdo", cmd_if.jdo, 38'h20_0000_00AA);
    check("ovr_valid", cmd_if.cmd_valid, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    cmd_if.cmd_ready = 1'b1;
    #1;
    check("ovr_drain", cmd_if.take_action, 4'b0100);
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("ovr_idle", cmd_if.cmd_valid, 0);
    repeat (3) tick();

    // Accept and new update in the same cycle; new update also carries a same-cycle IR of 2'b11.
    udr_capture(38'h00_0000_0111);
    repeat (3) tick();
    sr = 38'h3F_FFFF_FFFF;
    ir_in = 2'b11;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(); tick();
    cmd_if.cmd_ready = 1'b1;
    #1;
    check("sc_old_noact", cmd_if.take_no_action, 4'b0100);
    check("sc_old_act", cmd_if.take_action, 0);
    tick();
    check("sc_valid", cmd_if.cmd_valid, 1);
    check("sc_jdo", cmd_if.jdo, 38'h3F_FFFF_FFFF);
    check("sc_ir", cmd_if.cmd_ir, 2'b11);
    check("sc_ovr", overrun, 0);
    check("sc_new_act", cmd_if.take_action, 4'b1000);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick();
    check("sc_idle", cmd_if.cmd_valid, 0);
    cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();

    // vs_udr held high fires once.
    cmd_if.cmd_ready = 1'b1;
    sr = 38'h20_0000_0777;
    vs_udr = 1'b1;
    take_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cmd_if.take_action != 0) take_cnt++;
    end
    check("hold_once", take_cnt, 1);
    vs_udr = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) tick();

    // Long pend with no ready.
    udr_capture(38'h20_0000_0ABC);
    pend_cnt = 0;
    take_cnt = 0;
    if (cmd_if.cmd_valid) pend_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_if.cmd_valid) pend_cnt++;
      if ((cmd_if.take_action | cmd_if.take_no_action) != 0) take_cnt++;
    end
    check("to_nostrobe", take_cnt, 0);
`ifdef DEBUG_CMD_TIMEOUT_EN
    check("to_pend_cycles", pend_cnt, 16);
    check("to_flag", timeout, 1);
    check("to_idle", cmd_if.cmd_valid, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("to_clr", timeout, 0);
`else
    check("to_pend_cycles", pend_cnt, 21);
    check("to_flag", timeout, 0);
    check("to_still", cmd_if.cmd_valid, 1);
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
`endif
    repeat (3) tick();

    // Reset mid-pend clears outputs asynchronously.
    udr_capture(38'h20_0000_0F0F);
    check("mr_pre", cmd_if.cmd_valid, 1);
    #2;
    reset_n = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    #1;
    check("mr_valid", cmd_if.cmd_valid, 0);
    check("mr_jdo", cmd_if.jdo, 0);
    check("mr_take", cmd_if.take_action, 0);
    check("mr_state", dbg_state, 0);
    #3;
    reset_n = 1'b1;
    tick();
    check("mr_after", cmd_if.cmd_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
